// File: rtl/act_cell_bank_if.sv
// Bus bundle for act_cell_bank: operands and selects in, registered results out.
// master drives stimulus, slave is the cell bank itself.
interface act_cell_bank_if #(
  parameter int N = 8
);
  logic         en;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_ci;
  logic [N-1:0] add_s;
  logic         add_co;
  logic         c1_a0;
  logic         c1_a1;
  logic         c1_sa;
  logic         c1_b0;
  logic         c1_b1;
  logic         c1_sb;
  logic         c1_s0;
  logic         c1_s1;
  logic         c1_f;
  logic         c2_d0;
  logic         c2_d1;
  logic         c2_d2;
  logic         c2_d3;
  logic         c2_a0;
  logic         c2_a1;
  logic         c2_b0;
  logic         c2_b1;
  logic         c2_out;

  modport master (
    output en,
    output add_a,
    output add_b,
    output add_ci,
    output c1_a0,
    output c1_a1,
    output c1_sa,
    output c1_b0,
    output c1_b1,
    output c1_sb,
    output c1_s0,
    output c1_s1,
    output c2_d0,
    output c2_d1,
    output c2_d2,
    output c2_d3,
    output c2_a0,
    output c2_a1,
    output c2_b0,
    output c2_b1,
    input  add_s,
    input  add_co,
    input  c1_f,
    input  c2_out
  );

  modport slave (
    input  en,
    input  add_a,
    input  add_b,
    input  add_ci,
    input  c1_a0,
    input  c1_a1,
    input  c1_sa,
    input  c1_b0,
    input  c1_b1,
    input  c1_sb,
    input  c1_s0,
    input  c1_s1,
    input  c2_d0,
    input  c2_d1,
    input  c2_d2,
    input  c2_d3,
    input  c2_a0,
    input  c2_a1,
    input  c2_b0,
    input  c2_b1,
    output add_s,
    output add_co,
    output c1_f,
    output c2_out
  );
endinterface

// File: rtl/act_cell_bank.sv
// Registered bank of ripple adder, C1 mux/OR cell and C2 gated 4:1 mux cell.
// All results share one enable and one async active-low reset.
module act_cell_bank #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  act_cell_bank_if.slave   bus
);

  logic [N-1:0] sum_d;
  logic [N-1:0] sum_q;
  logic         co_d;
  logic         co_q;
  logic         carry;

  logic         c1_a;
  logic         c1_b;
  logic         c1_sel;
  logic         c1_d;
  logic         c1_q;

  logic         c2_hi;
  logic         c2_lo;
  logic         c2_d;
  logic         c2_q;

  // Explicit ripple chain so this cell matches the gate-level reference.
  always_comb begin
    carry = bus.add_ci;
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d[i] = bus.add_a[i] ^ bus.add_b[i] ^ carry;
      carry    = (bus.add_a[i] & bus.add_b[i])
               | (carry & (bus.add_a[i] ^ bus.add_b[i]));
    end
    co_d = carry;
  end

  always_comb begin
    c1_a   = bus.c1_sa ? bus.c1_a1 : bus.c1_a0;
    c1_b   = bus.c1_sb ? bus.c1_b1 : bus.c1_b0;
    c1_sel = bus.c1_s0 | bus.c1_s1;
    c1_d   = c1_sel ? c1_b : c1_a;
  end

  always_comb begin
    c2_hi = bus.c2_a0 & bus.c2_a1;
    c2_lo = bus.c2_b0 | bus.c2_b1;
    c2_d  = bus.c2_d0;
    case ({c2_hi, c2_lo})
      2'b00:   c2_d = bus.c2_d0;
      2'b01:   c2_d = bus.c2_d1;
      2'b10:   c2_d = bus.c2_d2;
      2'b11:   c2_d = bus.c2_d3;
      default: c2_d = bus.c2_d0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      co_q  <= 1'b0;
      c1_q  <= 1'b0;
      c2_q  <= 1'b0;
    end else if (bus.en) begin
      sum_q <= sum_d;
      co_q  <= co_d;
      c1_q  <= c1_d;
      c2_q  <= c2_d;
    end
  end

  assign bus.add_s  = sum_q;
  assign bus.add_co = co_q;
  assign bus.c1_f   = c1_q;
  assign bus.c2_out = c2_q;

endmodule

// File: tb/tb_act_cell_bank.sv
// Directed plus randomized check of act_cell_bank against an arithmetic model.
module tb_act_cell_bank;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [N-1:0] exp_s;
  logic         exp_co;
  logic         exp_f;
  logic         exp_c2;

  act_cell_bank_if #(.N(N)) bus ();

  act_cell_bank #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_eval();
    logic [N:0] t;
    logic [3:0] d;
    int         idx;
    t = {1'b0, bus.add_a} + {1'b0, bus.add_b} + (N+1)'(bus.add_ci);
    exp_s  = t[N-1:0];
    exp_co = t[N];
    if (bus.c1_s0 || bus.c1_s1)
      exp_f = bus.c1_sb ? bus.c1_b1 : bus.c1_b0;
    else
      exp_f = bus.c1_sa ? bus.c1_a1 : bus.c1_a0;
    d   = {bus.c2_d3, bus.c2_d2, bus.c2_d1, bus.c2_d0};
    idx = 2 * int'(bus.c2_a0 && bus.c2_a1) + int'(bus.c2_b0 || bus.c2_b1);
    exp_c2 = d[idx];
  endtask

  task automatic chk(input string tag);
    n_cmp++;
    assert (bus.add_s === exp_s) else begin
      n_err++;
      $error("FAIL %s add_s got %h exp %h", tag, bus.add_s, exp_s);
    end
    n_cmp++;
    assert (bus.add_co === exp_co) else begin
      n_err++;
      $error("FAIL %s add_co got %b exp %b", tag, bus.add_co, exp_co);
    end
    n_cmp++;
    assert (bus.c1_f === exp_f) else begin
      n_err++;
      $error("FAIL %s c1_f got %b exp %b", tag, bus.c1_f, exp_f);
    end
    n_cmp++;
    assert (bus.c2_out === exp_c2) else begin
      n_err++;
      $error("FAIL %s c2_out got %b exp %b", tag, bus.c2_out, exp_c2);
    end
  endtask

  task automatic tick(input string tag);
    if (rst && bus.en) model_eval();
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  task automatic clear_in();
    bus.add_a = '0; bus.add_b = '0; bus.add_ci = 1'b0;
    bus.c1_a0 = 0; bus.c1_a1 = 0; bus.c1_sa = 0;
    bus.c1_b0 = 0; bus.c1_b1 = 0; bus.c1_sb = 0;
    bus.c1_s0 = 0; bus.c1_s1 = 0;
    bus.c2_d0 = 0; bus.c2_d1 = 0; bus.c2_d2 = 0; bus.c2_d3 = 0;
    bus.c2_a0 = 0; bus.c2_a1 = 0; bus.c2_b0 = 0; bus.c2_b1 = 0;
  endtask

  task automatic rand_in();
    bus.add_a  = N'($urandom);
    bus.add_b  = N'($urandom);
    bus.add_ci = 1'($urandom);
    {bus.c1_a0, bus.c1_a1, bus.c1_sa, bus.c1_b0} = 4'($urandom);
    {bus.c1_b1, bus.c1_sb, bus.c1_s0, bus.c1_s1} = 4'($urandom);
    {bus.c2_d0, bus.c2_d1, bus.c2_d2, bus.c2_d3} = 4'($urandom);
    {bus.c2_a0, bus.c2_a1, bus.c2_b0, bus.c2_b1} = 4'($urandom);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b0;
    exp_s = '0; exp_co = 1'b0; exp_f = 1'b0; exp_c2 = 1'b0;
    #1;
    chk(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    clear_in();
    #2;
    async_reset("reset_init");

    // Reset with live inputs and enable, no clock needed.
    @(posedge clk); #1;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.add_a = 8'h5A; bus.add_b = 8'h33; bus.add_ci = 1'b1;
    bus.c1_s0 = 1; bus.c1_sb = 1; bus.c1_b1 = 1;
    bus.c2_a0 = 1; bus.c2_a1 = 1; bus.c2_d2 = 1;
    tick("preload");
    async_reset("reset_async");
    tick("reset_edge_ignored");
    rst = 1'b1;
    tick("reset_release");

    clear_in();
    bus.add_a = 8'hFF; bus.add_b = 8'h01; bus.add_ci = 0;
    tick("add_wrap");
    bus.add_a = 8'h05; bus.add_b = 8'hFA; bus.add_ci = 1;
    tick("sub_5_5");
    bus.add_a = 8'h02; bus.add_b = 8'hFC; bus.add_ci = 1;
    tick("sub_2_3");

    clear_in();
    bus.c1_b1 = 1; bus.c1_sb = 1;
    for (int s = 0; s < 4; s++) begin
      {bus.c1_s0, bus.c1_s1} = 2'(s);
      tick("c1_or");
    end
    clear_in();
    bus.c1_sa = 1; bus.c1_a1 = 1;
    tick("c1_mux_a");
    bus.c1_s1 = 1; bus.c1_sb = 0; bus.c1_b0 = 0;
    tick("c1_mux_b");

    clear_in();
    bus.c2_d1 = 1; bus.c2_d3 = 1;
    bus.c2_a0 = 1;
    tick("c2_d0");
    bus.c2_b1 = 1;
    tick("c2_d1");
    bus.c2_a1 = 1; bus.c2_b1 = 0;
    tick("c2_d2");
    bus.c2_b0 = 1;
    tick("c2_d3");

    // Enable hold across three cycles of changing inputs.
    rand_in();
    tick("hold_load");
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_in();
      tick("hold");
    end
    bus.en = 1'b1;
    tick("hold_release");

    for (int k = 0; k < 300; k++) begin
      rand_in();
      bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        async_reset("rand_reset");
        tick("rand_reset_edge");
        rst = 1'b1;
      end
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
